alu_op_issue: RTL

//   Front end that drives the ALU. It accepts {alu_op, funct, operands} over a valid/ready handshake
//   and decodes them into the 4-bit ALU control code.
//   It holds the operation stable on the ALU ports for one cycle, then captures the ALU result and zero flag

---
 rtl/alu_op_issue_if.sv | 36 +++
 rtl/alu_op_issue.sv | 109 ++++++++++
 2 files changed

// File: rtl/alu_op_issue_if.sv
// Request, ALU-facing and response signals of the ALU issue front end.
// The slave view is the issue block itself; the master view is its environment.
interface alu_op_issue_if #(
  parameter int WIDTH = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [2:0]       alu_op_i;
  logic [5:0]       funct_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [3:0]       alu_ctrl_o;
  logic [WIDTH-1:0] alu_src1_o;
  logic [WIDTH-1:0] alu_src2_o;
  logic [WIDTH-1:0] alu_result_i;
  logic             alu_zero_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] out_result_o;
  logic             out_zero_o;
  logic             out_illegal_o;

  modport slave (
    input  in_valid_i, alu_op_i, funct_i, src1_i, src2_i,
    input  alu_result_i, alu_zero_i, out_ready_i,
    output in_ready_o, alu_ctrl_o, alu_src1_o, alu_src2_o,
    output out_valid_o, out_result_o, out_zero_o, out_illegal_o
  );

  modport master (
    output in_valid_i, alu_op_i, funct_i, src1_i, src2_i,
    output alu_result_i, alu_zero_i, out_ready_i,
    input  in_ready_o, alu_ctrl_o, alu_src1_o, alu_src2_o,
    input  out_valid_o, out_result_o, out_zero_o, out_illegal_o
  );
endinterface

// File: rtl/alu_op_issue.sv
// Two-stage ALU issue front end: decodes {alu_op, funct} into the ALU control code,
// holds the operation on the ALU ports for one cycle, then registers result/zero/illegal.
module alu_op_issue #(
  parameter int         WIDTH        = 32,
  parameter logic [3:0] ILLEGAL_CTRL = 4'd15
) (
  input logic           clk_i,
  input logic           rst_i,
  alu_op_issue_if.slave bus
);

  // Returns {illegal, ctrl}.
  function automatic logic [4:0] decode(input logic [2:0] op, input logic [5:0] funct);
    logic [4:0] d;
    d = {1'b1, ILLEGAL_CTRL};
    case (op)
      3'b000:  d = {1'b0, 4'd2};
      3'b001:  d = {1'b0, 4'd6};
      3'b011:  d = {1'b0, 4'd7};
      3'b100:  d = {1'b0, 4'd1};
      3'b101:  d = {1'b0, 4'd0};
      3'b010: begin
        case (funct)
          6'h20:   d = {1'b0, 4'd2};
          6'h22:   d = {1'b0, 4'd6};
          6'h24:   d = {1'b0, 4'd0};
          6'h25:   d = {1'b0, 4'd1};
          6'h27:   d = {1'b0, 4'd12};
          6'h2A:   d = {1'b0, 4'd7};
          default: d = {1'b1, ILLEGAL_CTRL};
        endcase
      end
      default: d = {1'b1, ILLEGAL_CTRL};
    endcase
    return d;
  endfunction

  logic             s1_valid_r;
  logic [3:0]       s1_ctrl_r;
  logic [WIDTH-1:0] s1_src1_r;
  logic [WIDTH-1:0] s1_src2_r;
  logic             s1_illegal_r;
  logic             s2_valid_r;
  logic [WIDTH-1:0] s2_result_r;
  logic             s2_zero_r;
  logic             s2_illegal_r;
  logic [4:0]       dec_s;
  logic             s2_load_s;
  logic             in_ready_s;
  logic             accept_s;

  // Handshake decisions and request decode.
  always_comb begin
    dec_s      = decode(bus.alu_op_i, bus.funct_i);
    s2_load_s  = s1_valid_r & (~s2_valid_r | bus.out_ready_i);
    in_ready_s = ~s1_valid_r | s2_load_s;
    accept_s   = bus.in_valid_i & in_ready_s;
  end

  // Issue stage: data regs only change on accept so the ALU inputs stay quiet when idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_r   <= 1'b0;
      s1_ctrl_r    <= 4'd0;
      s1_src1_r    <= '0;
      s1_src2_r    <= '0;
      s1_illegal_r <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r   <= 1'b1;
      s1_ctrl_r    <= dec_s[3:0];
      s1_src1_r    <= bus.src1_i;
      s1_src2_r    <= bus.src2_i;
      s1_illegal_r <= dec_s[4];
    end else if (s2_load_s) begin
      s1_valid_r   <= 1'b0;
    end else begin
      s1_valid_r   <= s1_valid_r;
    end
  end

  // Response stage: captures the combinational ALU answer for the op held in S1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid_r   <= 1'b0;
      s2_result_r  <= '0;
      s2_zero_r    <= 1'b0;
      s2_illegal_r <= 1'b0;
    end else if (s2_load_s) begin
      s2_valid_r   <= 1'b1;
      s2_result_r  <= bus.alu_result_i;
      s2_zero_r    <= bus.alu_zero_i;
      s2_illegal_r <= s1_illegal_r;
    end else if (bus.out_ready_i) begin
      s2_valid_r   <= 1'b0;
    end else begin
      s2_valid_r   <= s2_valid_r;
    end
  end

  assign bus.in_ready_o    = in_ready_s;
  assign bus.alu_ctrl_o    = s1_ctrl_r;
  assign bus.alu_src1_o    = s1_src1_r;
  assign bus.alu_src2_o    = s1_src2_r;
  assign bus.out_valid_o   = s2_valid_r;
  assign bus.out_result_o  = s2_result_r;
  assign bus.out_zero_o    = s2_zero_r;
  assign bus.out_illegal_o = s2_illegal_r;

endmodule
